regfile_wb_arbiter: RTL

Write-port arbiter and sequencer for the 32x32 register file. Two writeback requesters share the register file's single write port: A is the ALU writeback and B is the memory/load writeback. Each requester has a small FIFO, and the block grants the port round-robin. It drives the file's `RegWrite`, `WriteRegister` and `WriteData` from a registered output stage. It also reports whether a queried register still has a write pending, for hazard detection.

---
 rtl/regfile_arb_pkg.sv | 22 ++
 rtl/wb_fifo.sv | 103 ++++++++++
 rtl/regfile_wb_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Register 0 is hard-wired; writes to it are accepted and then dropped.
    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Identifies a writeback requester (A = ALU, B = memory/load).
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    // One queued register-file write.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] wreg;
        logic [DEF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small per-requester write queue with per-entry hazard match outputs.
module wb_fifo #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_reg,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] head_reg,
    output logic [DATA_W-1:0] head_data,
    input  logic [ADDR_W-1:0] query1,
    input  logic [ADDR_W-1:0] query2,
    output logic [DEPTH-1:0]  match1,
    output logic [DEPTH-1:0]  match2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] reg_q  [DEPTH];
    logic [ADDR_W-1:0] reg_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    // Next-state for storage, pointers and occupancy; push and pop never target the same slot.
    always_comb begin
        reg_d    = reg_q;
        data_d   = data_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            reg_d[wr_ptr_q]   = push_reg;
            data_d[wr_ptr_q]  = push_data;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue state register; reset empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            reg_q    <= reg_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Compare each occupied slot against both hazard query indices.
    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match1[i] = valid_q[i] && (reg_q[i] == query1);
            match2[i] = valid_q[i] && (reg_q[i] == query2);
        end
    end

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == CNT_W'(0));
    assign head_reg  = reg_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between the
// ALU (A) and load (B) writeback queues, with hazard query outputs.
module regfile_wb_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              A_Valid,
    output logic              A_Ready,
    input  logic [ADDR_W-1:0] A_Reg,
    input  logic [DATA_W-1:0] A_Data,
    input  logic              B_Valid,
    output logic              B_Ready,
    input  logic [ADDR_W-1:0] B_Reg,
    input  logic [DATA_W-1:0] B_Data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] Query1,
    input  logic [ADDR_W-1:0] Query2,
    output logic              Pending1,
    output logic              Pending2,
    output logic              Busy
);

    logic              a_full_s, a_empty_s, b_full_s, b_empty_s;
    logic              a_push_s, b_push_s;
    logic              grant_a_s, grant_b_s;
    logic [ADDR_W-1:0] a_head_reg_s, b_head_reg_s;
    logic [DATA_W-1:0] a_head_data_s, b_head_data_s;
    logic [DEPTH-1:0]  a_m1_s, a_m2_s, b_m1_s, b_m2_s;

    req_id_t           last_q, last_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Ready reflects only the current occupancy, never a same-cycle pop.
    assign A_Ready = ~Reset & ~a_full_s;
    assign B_Ready = ~Reset & ~b_full_s;

    // Register-0 writes complete the handshake but are never queued.
    assign a_push_s = A_Valid & A_Ready & (A_Reg != ADDR_W'(REG_ZERO));
    assign b_push_s = B_Valid & B_Ready & (B_Reg != ADDR_W'(REG_ZERO));

    wb_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
        .clk(Clk), .rst(Reset), .push(a_push_s), .push_reg(A_Reg), .push_data(A_Data),
        .pop(grant_a_s), .full(a_full_s), .empty(a_empty_s),
        .head_reg(a_head_reg_s), .head_data(a_head_data_s),
        .query1(Query1), .query2(Query2), .match1(a_m1_s), .match2(a_m2_s)
    );

    wb_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
        .clk(Clk), .rst(Reset), .push(b_push_s), .push_reg(B_Reg), .push_data(B_Data),
        .pop(grant_b_s), .full(b_full_s), .empty(b_empty_s),
        .head_reg(b_head_reg_s), .head_data(b_head_data_s),
        .query1(Query1), .query2(Query2), .match1(b_m1_s), .match2(b_m2_s)
    );

    // Last-grant state register; resets to B so A wins the first tie.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_q <= REQ_B;
        end else begin
            last_q <= last_d;
        end
    end

    // Last-grant next state: only a contested grant moves the flag.
    always_comb begin
        last_d = last_q;
        if (!a_empty_s && !b_empty_s) begin
            last_d = (last_q == REQ_B) ? REQ_A : REQ_B;
        end else begin
            last_d = last_q;
        end
    end

    // Grant outputs: a lone non-empty queue wins, a tie goes to the one not granted last.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (!a_empty_s && !b_empty_s) begin
            grant_a_s = (last_q == REQ_B);
            grant_b_s = (last_q == REQ_A);
        end else begin
            grant_a_s = !a_empty_s;
            grant_b_s = !b_empty_s;
        end
    end

    // Output stage next state: load the popped entry, otherwise hold index/data and drop enable.
    always_comb begin
        regwrite_d = grant_a_s | grant_b_s;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        if (grant_a_s) begin
            wreg_d  = a_head_reg_s;
            wdata_d = a_head_data_s;
        end else if (grant_b_s) begin
            wreg_d  = b_head_reg_s;
            wdata_d = b_head_data_s;
        end else begin
            wreg_d  = wreg_q;
            wdata_d = wdata_q;
        end
    end

    // Registered write port to the register file.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

    assign RegWrite      = regwrite_q;
    assign WriteRegister = wreg_q;
    assign WriteData     = wdata_q;

    // A query hits any queued entry or the write currently on the port; index 0 never hits.
    assign Pending1 = (Query1 != ADDR_W'(REG_ZERO)) &
                      ((|a_m1_s) | (|b_m1_s) | (regwrite_q & (wreg_q == Query1)));
    assign Pending2 = (Query2 != ADDR_W'(REG_ZERO)) &
                      ((|a_m2_s) | (|b_m2_s) | (regwrite_q & (wreg_q == Query2)));

    assign Busy = ~a_empty_s | ~b_empty_s | regwrite_q;

endmodule
